// File: rtl/vendo_change_dispenser_if.sv
// Request and hopper signals between the vending controller, the change dispenser and the coin hopper.
// With VENDO_HOPPER_EMPTY_EN defined, the hopper also reports an empty 5p tube.
interface vendo_change_dispenser_if #(
    parameter int AMT_W = 4
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             coin_ack;
    logic             eject1;
    logic             eject5;
`ifdef VENDO_HOPPER_EMPTY_EN
    logic             hopper5_empty;

    modport master (
        output req_valid, req_amt, coin_ack, hopper5_empty,
        input  req_ready, eject1, eject5
    );

    modport slave (
        input  req_valid, req_amt, coin_ack, hopper5_empty,
        output req_ready, eject1, eject5
    );
`else
    modport master (
        output req_valid, req_amt, coin_ack,
        input  req_ready, eject1, eject5
    );

    modport slave (
        input  req_valid, req_amt, coin_ack,
        output req_ready, eject1, eject5
    );
`endif
endinterface

// File: rtl/vendo_change_dispenser.sv
// Change payout: pays a peso amount with 5p/1p hopper eject pulses, waiting for a drop ack per coin.
// Optional VENDO_HOPPER_EMPTY_EN forces 1p coins while the hopper reports its 5p tube empty.
module vendo_change_dispenser #(
    parameter int AMT_W     = 4,
    parameter int PULSE_LEN = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    vendo_change_dispenser_if.slave bus,
    input  logic                    clr_fault,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic [AMT_W-1:0]        remaining,
    output logic [2:0]              cstate
);
    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_SELECT = 3'b001;
    localparam logic [2:0] S_EJECT  = 3'b010;
    localparam logic [2:0] S_WAIT   = 3'b011;
    localparam logic [2:0] S_DONE   = 3'b100;
    localparam logic [2:0] S_FAULT  = 3'b101;

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]       state;
    logic             coin5;
    logic [PW-1:0]    pcnt;
    logic [TW-1:0]    timer;
    logic [AMT_W-1:0] coin_val;
    logic             take5;

    assign coin_val = coin5 ? AMT_W'(5) : AMT_W'(1);

    always_comb begin
        take5 = (remaining >= AMT_W'(5));
`ifdef VENDO_HOPPER_EMPTY_EN
        if (bus.hopper5_empty) take5 = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            coin5     <= 1'b0;
            pcnt      <= '0;
            timer     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        remaining <= bus.req_amt;
                        state     <= (bus.req_amt == '0) ? S_DONE : S_SELECT;
                    end
                end
                S_SELECT: begin
                    coin5 <= take5;
                    pcnt  <= '0;
                    state <= S_EJECT;
                end
                S_EJECT: begin
                    if (pcnt == PW'(PULSE_LEN - 1)) begin
                        timer <= '0;
                        state <= S_WAIT;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                S_WAIT: begin
                    // an ack on the timeout cycle still counts as a paid coin
                    if (bus.coin_ack) begin
                        remaining <= remaining - coin_val;
                        state     <= (remaining == coin_val) ? S_DONE : S_SELECT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state <= S_FAULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DONE: begin
                    remaining <= '0;
                    state     <= S_IDLE;
                end
                S_FAULT: begin
                    if (clr_fault) begin
                        remaining <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.eject5    = (state == S_EJECT) && coin5;
    assign bus.eject1    = (state == S_EJECT) && !coin5;
    assign busy          = (state != S_IDLE) && (state != S_FAULT);
    assign done          = (state == S_DONE);
    assign fault         = (state == S_FAULT);
    assign cstate        = state;
endmodule

// File: tb/tb_vendo_change_dispenser.sv
// Scoreboard bench for vendo_change_dispenser: directed scenarios plus randomized payouts
// checked against a coin-list model; exercises VENDO_HOPPER_EMPTY_EN when defined.
module tb_vendo_change_dispenser;
    localparam int AMT_W     = 4;
    localparam int PULSE_LEN = 2;
    localparam int TIMEOUT   = 255;
    localparam int K_COIN    = 0;
    localparam int K_DONE    = 1;
    localparam int K_FAULT   = 2;

    typedef struct {
        int kind;
        int coin;
        int rem;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr_fault = 1'b0;
    logic             busy, done, fault;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       cstate;
    logic             hop_ack = 1'b0;
    logic             stray_ack = 1'b0;
    bit               ack_en = 1'b1;
    int               ack_dly = 3;
    int               total = 0;
    int               bad = 0;
    ev_t              expq[$];

    vendo_change_dispenser_if #(.AMT_W(AMT_W)) bus();

    vendo_change_dispenser #(
        .AMT_W    (AMT_W),
        .PULSE_LEN(PULSE_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clr_fault(clr_fault),
        .busy     (busy),
        .done     (done),
        .fault    (fault),
        .remaining(remaining),
        .cstate   (cstate)
    );

    always #5 clk = ~clk;

    assign bus.coin_ack = hop_ack | stray_ack;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Payout as a coin list: as many 5p as fit (none if the tube is empty), rest in 1p
    task automatic model_push(input int amt, input bit empty5, input bit acks);
        int  n5;
        int  rem;
        ev_t ev;
        n5  = empty5 ? 0 : amt / 5;
        rem = amt;
        for (int i = 0; i < amt - 4 * n5; i++) begin
            ev.kind = K_COIN;
            ev.coin = (i < n5) ? 5 : 1;
            ev.rem  = rem;
            expq.push_back(ev);
            if (!acks) break;
            rem -= ev.coin;
        end
        ev.kind = (acks || amt == 0) ? K_DONE : K_FAULT;
        ev.coin = 0;
        ev.rem  = rem;
        expq.push_back(ev);
    endtask

    // Returns at 1ns after edge 2 of the accepted request
    task automatic issue(input int amt, input bit empty5, input bit acks, input bit stray);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", bus.req_ready, 1);
        model_push(amt, empty5, acks);
        ack_en = acks;
`ifdef VENDO_HOPPER_EMPTY_EN
        bus.hopper5_empty = empty5;
`endif
        bus.req_amt   = AMT_W'(amt);
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("ready_after_accept", bus.req_ready, 0);
        if (amt == 0) begin
            check("zero_done_latency", done, 1);
            @(posedge clk); #1;
            check("zero_ready_back", bus.req_ready, 1);
            check("zero_done_once", done, 0);
        end else begin
            check("select_state", cstate, 1);
            check("no_pulse_in_select", bus.eject1 | bus.eject5, 0);
            if (stray) stray_ack = 1'b1;
            @(posedge clk); #1;
            stray_ack = 1'b0;
            check("pulse_latency", bus.eject1 | bus.eject5, 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(expq.size() == 0 && bus.req_ready) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", n < 3000, 1);
        expq.delete();
    endtask

    task automatic wait_pulse_end();
        int n;
        n = 0;
        while ((bus.eject1 | bus.eject5) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("pulse_end_timeout", n < 50, 1);
    endtask

    // Monitor: pops the expected event whenever the DUT presents a pulse, done or fault
    initial begin : monitor
        ev_t ev;
        int  width;
        bit  pe, pf, e;
        width = 0;
        pe = 1'b0;
        pf = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                width = 0;
                pe = 1'b0;
                pf = 1'b0;
                continue;
            end
            if (bus.eject1 && bus.eject5) check("eject_exclusive", 1, 0);
            e = bus.eject1 | bus.eject5;
            if (e && !pe) begin
                if (expq.size() == 0) check("unexpected_pulse", 1, 0);
                else begin
                    ev = expq.pop_front();
                    check("pulse_kind", K_COIN, ev.kind);
                    check("coin_value", bus.eject5 ? 5 : 1, ev.coin);
                    check("rem_at_pulse", remaining, ev.rem);
                end
                width = 1;
            end else if (e) begin
                width++;
            end else if (pe) begin
                check("pulse_width", width, PULSE_LEN);
            end
            pe = e;
            if (done) begin
                if (expq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    ev = expq.pop_front();
                    check("done_kind", K_DONE, ev.kind);
                    check("rem_at_done", remaining, 0);
                    check("fault_at_done", fault, 0);
                end
            end
            if (fault && !pf) begin
                if (expq.size() == 0) check("unexpected_fault", 1, 0);
                else begin
                    ev = expq.pop_front();
                    check("fault_kind", K_FAULT, ev.kind);
                    check("rem_at_fault", remaining, ev.rem);
                    check("busy_at_fault", busy, 0);
                end
            end
            pf = fault;
        end
    end

    // Hopper: acknowledges each coin ack_dly cycles after its eject pulse ends
    initial begin : hopper
        bit pe;
        pe = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                pe = 1'b0;
                continue;
            end
            if (pe && !(bus.eject1 | bus.eject5) && ack_en) begin
                repeat (ack_dly) @(posedge clk);
                @(negedge clk);
                hop_ack = 1'b1;
                @(negedge clk);
                hop_ack = 1'b0;
                pe = 1'b0;
            end else begin
                pe = bus.eject1 | bus.eject5;
            end
        end
    end

    initial begin : stim
        int n;
        int amt;
        bit emp;
        bus.req_valid = 1'b0;
        bus.req_amt   = '0;
`ifdef VENDO_HOPPER_EMPTY_EN
        bus.hopper5_empty = 1'b0;
`endif
        #2;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_eject1", bus.eject1, 0);
        check("rst_eject5", bus.eject5, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_remaining", remaining, 0);
        check("rst_cstate", cstate, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 7p: 5 + 1 + 1
        ack_dly = 3;
        issue(7, 1'b0, 1'b1, 1'b0);
        wait_idle();
        check("fault_after_7", fault, 0);

        // 0p: straight to done
        issue(0, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // 5p with a silent hopper: timeout then sticky fault
        issue(5, 1'b0, 1'b0, 1'b0);
        wait_pulse_end();
        n = 0;
        while (!fault && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("fault_latency", n, TIMEOUT);
        check("fault_remaining", remaining, 5);
        check("fault_busy", busy, 0);
        check("fault_ready", bus.req_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        check("fault_sticky", fault, 1);
        @(negedge clk);
        clr_fault = 1'b1;
        @(posedge clk); #1;
        clr_fault = 1'b0;
        check("clr_state", cstate, 0);
        check("clr_remaining", remaining, 0);
        check("clr_fault_low", fault, 0);
        expq.delete();
        ack_en = 1'b1;

        // reset in the middle of a 5p pulse
        issue(10, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_eject5", bus.eject5, 0);
        check("midrst_state", cstate, 0);
        check("midrst_remaining", remaining, 0);
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(3, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // stray ack in SELECT and a new request during WAIT_ACK are both ignored
        issue(7, 1'b0, 1'b1, 1'b1);
        wait_pulse_end();
        bus.req_amt   = AMT_W'(9);
        bus.req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("no_queued_request", cstate, 0);

`ifdef VENDO_HOPPER_EMPTY_EN
        issue(6, 1'b1, 1'b1, 1'b0);
        wait_idle();
`endif

        for (int i = 0; i < 25; i++) begin
            amt     = int'($urandom_range(0, 15));
            ack_dly = int'($urandom_range(0, 6));
`ifdef VENDO_HOPPER_EMPTY_EN
            emp = bit'($urandom_range(0, 1));
`else
            emp = 1'b0;
`endif
            issue(amt, emp, 1'b1, 1'b0);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
